alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle controller for the shared 8-bit combinational ALU. Accepts one command at a time
//  (valid/ready), drives the ALU's optype/OP/acc_in/reg_in pins for 1-8 cycles, captures OUT/c/z/n.
//  Returns a 16-bit result plus flags (valid/ready). Adds ADD16/SUB16 (carry chaining) and
//  MUL8 (shift-add) on top of single ALU passes. Sits between decode/execute and the ALU instance.
// PARAMETERS
//  W  8  ALU datapath width; results are 2*W bits; MUL iteration count = W
// PORTS
//  clk        in   1    clock, all state on rising edge
//  reset      in   1    asynchronous, active-high reset
//  cmd_valid  in   1    command present
//  cmd_ready  out  1    high only in IDLE
//  cmd_op     in   3    0 PASS, 1 ADD16, 2 SUB16, 3 MUL8, 4-7 reserved
//  cmd_aluop  in   4    ALU OP code, used by PASS only
//  cmd_a      in   16   operand A (PASS/MUL8 use [7:0])
//  cmd_b      in   16   operand B (PASS/MUL8 use [7:0])
//  rsp_valid  out  1    result present; held until rsp_ready
//  rsp_ready  in   1    consumer accepts result
//  rsp_data   out  16   result
//  rsp_c/z/n  out  1    carry-or-borrow / zero / negative
//  alu_optype out  1    to ALU optype; 0 only in exec states, 1 otherwise (ALU idle, OUT=0)
//  alu_op     out  4    to ALU OP
//  alu_acc    out  8    to ALU acc_in
//  alu_reg    out  8    to ALU reg_in
//  alu_out    in   8    from ALU OUT
//  alu_c/z/n  in   1    from ALU flags
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; rsp_valid=0; rsp_data=0; flags=0; alu_optype=1; alu_op/acc/reg=0.
//  ALU drive: combinational from operand/state regs. Results captured at the edge ending each exec cycle.
//  States: IDLE, PASS, LO, HI, FIX, MUL, DONE. Accept = cmd_valid & cmd_ready; operands latched.
//  PASS: one cycle, alu_op=cmd_aluop, acc=a[7:0], reg=b[7:0]; rsp_data={8'h00,alu_out}, flags=ALU's.
//  ADD16/SUB16 (OP 0010/0011):
//   LO: acc=a_lo, reg=b_lo -> res_lo, k=alu_c.
//   HI: acc=a_hi, reg=b_hi -> res_hi, c1=alu_c.
//   FIX only if k=1: acc=res_hi, reg=8'h01, same OP -> res_hi, c2=alu_c; else c2=0.
//   rsp_c=c1|c2 (carry for ADD, borrow for SUB). z=(data==0). n=data[15].
//  MUL8: hi=0, lo=b[7:0], mc=a[7:0], cnt=0. W MUL cycles, alu_op=ADD, acc=hi, reg=lo[0]?mc:0.
//   Each edge: {hi,lo} <= {alu_c,alu_out,lo}>>1; cnt++. Leave after cnt==W-1.
//   rsp_data={hi,lo}; c=0; z=(data==0); n=data[15].
//  Reserved cmd_op: PASS-length single cycle, ALU idle, rsp_data=0, flags=0.
//  Latency (accept edge -> rsp_valid rise): PASS/reserved 1; ADD16/SUB16 2, or 3 with FIX; MUL8 W.
//  DONE: rsp_valid=1; outputs stable while rsp_ready=0; rsp_valid & rsp_ready -> IDLE next edge.
//  No new command in the handshake cycle; earliest next accept is the following cycle.
//  cmd_valid held while busy is ignored, not lost. Upstream keeps it asserted until cmd_ready.
//  Reset mid-operation: immediate return to reset values; in-flight command and response discarded.
// STRUCTURE
//  alu_pkg: ALU OP localparams (ADD 0010, SUB 0011, SHL 0100, SHR 0101, AND 0110, OR 0111,
//   XOR 1000, CMP 1010); seq_cmd_e (PASS/ADD16/SUB16/MUL8); seq_state_e.
//  One FSM process plus one datapath-register process. No sub-module.
//  ALU stays external so a future arbiter can share it.
// TESTING
//  1 PASS OP=0010 a=F0 b=20 -> data 0010, c=1; rsp_valid 1 cycle after accept.
//  2 ADD16 00FF+0001 -> 0100, c=0, 3 ALU cycles. FFFF+0001 -> 0000, c=1, z=1.
//    1234+0101 -> 1335, 2 cycles.
//  3 SUB16 0100-0001 -> 00FF, c=0, n=0. 0000-0001 -> FFFF, c=1, n=1. 5555-5555 -> 0000, z=1.
//  4 MUL8 FF*FF -> FE01 after 8 cycles; 00*37 -> 0000, z=1; 0D*0B -> 008F.
//    Check alu_optype=1 outside exec states.
//  5 rsp_ready low 5 cycles -> data/flags stable, cmd_ready=0. Back-to-back cmds with cmd_valid
//    held -> each accepted exactly once.
//  6 reset pulse in MUL cycle 4 -> outputs at reset values immediately.
//    Next ADD16 0001+0001 -> 0002 correct.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU opcodes, command encodings and FSM states.
package alu_pkg;

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0011;
    localparam logic [3:0] AluShl = 4'b0100;
    localparam logic [3:0] AluShr = 4'b0101;
    localparam logic [3:0] AluAnd = 4'b0110;
    localparam logic [3:0] AluOr  = 4'b0111;
    localparam logic [3:0] AluXor = 4'b1000;
    localparam logic [3:0] AluCmp = 4'b1010;

    typedef enum logic [2:0] {
        CmdPass  = 3'd0,
        CmdAdd16 = 3'd1,
        CmdSub16 = 3'd2,
        CmdMul8  = 3'd3
    } seq_cmd_e;

    typedef enum logic [2:0] {
        StIdle,
        StPass,
        StLo,
        StHi,
        StFix,
        StMul,
        StDone
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer.sv
// Multi-cycle controller driving an external W-bit ALU: single passes, 2W-bit add/sub with
// carry chaining, and WxW shift-add multiply, with valid/ready on both command and response.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [3:0]     cmd_aluop,
    input  logic [2*W-1:0] cmd_a,
    input  logic [2*W-1:0] cmd_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*W-1:0] rsp_data,
    output logic           rsp_c,
    output logic           rsp_z,
    output logic           rsp_n,
    output logic           alu_optype,
    output logic [3:0]     alu_op,
    output logic [W-1:0]   alu_acc,
    output logic [W-1:0]   alu_reg,
    input  logic [W-1:0]   alu_out,
    input  logic           alu_c,
    input  logic           alu_z,
    input  logic           alu_n
);

    localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

    seq_state_e     state_q, state_d;
    seq_cmd_e       cmd_q, cmd_d;
    logic           rsvd_q, rsvd_d;
    logic [3:0]     aluop_q, aluop_d;
    logic [2*W-1:0] a_q, a_d, b_q, b_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           k_q, k_d, c1_q, c1_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           rc_q, rc_d, rz_q, rz_d, rn_q, rn_d;

    logic [3:0]     arith_op;
    logic [2*W:0]   mul_sum;
    logic [2*W-1:0] mul_next;
    logic           mul_last;

    assign arith_op  = (cmd_q == CmdSub16) ? AluSub : AluAdd;
    // Carry out of the top byte becomes the MSB after the right shift.
    assign mul_sum   = {alu_c, alu_out, lo_q};
    assign mul_next  = mul_sum[2*W:1];
    assign mul_last  = (cnt_q == CntW'(W - 1));

    assign cmd_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StDone);
    assign rsp_data  = {hi_q, lo_q};
    assign rsp_c     = rc_q;
    assign rsp_z     = rz_q;
    assign rsp_n     = rn_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        CmdAdd16, CmdSub16: state_d = StLo;
                        CmdMul8:            state_d = StMul;
                        default:            state_d = StPass;
                    endcase
                end
            end
            StPass:  state_d = StDone;
            StLo:    state_d = StHi;
            StHi:    state_d = k_q ? StFix : StDone;
            StFix:   state_d = StDone;
            StMul:   state_d = mul_last ? StDone : StMul;
            StDone:  state_d = rsp_ready ? StIdle : StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_optype = 1'b1;
        alu_op     = '0;
        alu_acc    = '0;
        alu_reg    = '0;
        unique case (state_q)
            StPass: begin
                if (!rsvd_q) begin
                    alu_optype = 1'b0;
                    alu_op     = aluop_q;
                    alu_acc    = a_q[W-1:0];
                    alu_reg    = b_q[W-1:0];
                end
            end
            StLo: begin
                alu_optype = 1'b0;
                alu_op     = arith_op;
                alu_acc    = a_q[W-1:0];
                alu_reg    = b_q[W-1:0];
            end
            StHi: begin
                alu_optype = 1'b0;
                alu_op     = arith_op;
                alu_acc    = a_q[2*W-1:W];
                alu_reg    = b_q[2*W-1:W];
            end
            StFix: begin
                alu_optype = 1'b0;
                alu_op     = arith_op;
                alu_acc    = hi_q;
                alu_reg    = W'(1);
            end
            StMul: begin
                alu_optype = 1'b0;
                alu_op     = AluAdd;
                alu_acc    = hi_q;
                alu_reg    = lo_q[0] ? a_q[W-1:0] : '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_d   = cmd_q;
        rsvd_d  = rsvd_q;
        aluop_d = aluop_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        k_d     = k_q;
        c1_d    = c1_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        rz_d    = rz_q;
        rn_d    = rn_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    rsvd_d  = (cmd_op > 3'd3);
                    cmd_d   = (cmd_op > 3'd3) ? CmdPass : seq_cmd_e'(cmd_op);
                    aluop_d = cmd_aluop;
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    hi_d    = '0;
                    lo_d    = cmd_b[W-1:0];
                    k_d     = 1'b0;
                    c1_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StPass: begin
                hi_d = '0;
                lo_d = rsvd_q ? '0 : alu_out;
                rc_d = rsvd_q ? 1'b0 : alu_c;
                rz_d = rsvd_q ? 1'b0 : alu_z;
                rn_d = rsvd_q ? 1'b0 : alu_n;
            end
            StLo: begin
                lo_d = alu_out;
                k_d  = alu_c;
            end
            StHi: begin
                hi_d = alu_out;
                c1_d = alu_c;
                if (!k_q) begin
                    rc_d = alu_c;
                    rz_d = ({alu_out, lo_q} == '0);
                    rn_d = alu_out[W-1];
                end
            end
            StFix: begin
                hi_d = alu_out;
                rc_d = c1_q | alu_c;
                rz_d = ({alu_out, lo_q} == '0);
                rn_d = alu_out[W-1];
            end
            StMul: begin
                hi_d  = mul_next[2*W-1:W];
                lo_d  = mul_next[W-1:0];
                cnt_d = cnt_q + 1'b1;
                if (mul_last) begin
                    rc_d = 1'b0;
                    rz_d = (mul_next == '0);
                    rn_d = mul_next[2*W-1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q   <= CmdPass;
            rsvd_q  <= 1'b0;
            aluop_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            k_q     <= 1'b0;
            c1_q    <= 1'b0;
            cnt_q   <= '0;
            rc_q    <= 1'b0;
            rz_q    <= 1'b0;
            rn_q    <= 1'b0;
        end else begin
            cmd_q   <= cmd_d;
            rsvd_q  <= rsvd_d;
            aluop_q <= aluop_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            k_q     <= k_d;
            c1_q    <= c1_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            rz_q    <= rz_d;
            rn_q    <= rn_d;
        end
    end

endmodule
